// File: rtl/const_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : const_div_seq
// Brief    : Sequential unsigned divider by a compile-time constant D.
//            Retires C dividend bits per cycle, MSB first, with the radix-2^C
//            remainder recurrence. Valid/ready handshake on both sides.
//            Optional macro CDIV_REM_EN exposes the registered remainder on
//            out_remainder; without it the remainder stays internal.
// Revision : 1.0 - initial release
// ============================================================================
module const_div_seq #(
    parameter int N     = 60,
    parameter int D     = 47,
    parameter int C     = 6,
    parameter int RW    = $clog2(D),
    parameter int STEPS = N / C
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_dividend,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_quotient,
`ifdef CDIV_REM_EN
    output logic [RW-1:0] out_remainder,
`endif
    output logic          busy
);

    // Elaboration-time sanity checks on the configuration.
    if ((N % C) != 0) begin : g_bad_width
        $error("const_div_seq: N must be a multiple of C");
    end
    if ((D < 2) || (D >= (1 << C))) begin : g_bad_divisor
        $error("const_div_seq: D must satisfy 2 <= D < 2^C");
    end

    localparam int             c_cw   = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int             c_vw   = RW + C;
    localparam logic [c_vw-1:0] c_d    = c_vw'(D);
    localparam logic [c_cw-1:0] c_last = c_cw'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_shift;
    logic [RW-1:0]   r_rem;
    logic [c_cw-1:0] r_cnt;
    logic [N-1:0]    r_quo;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;
`ifdef CDIV_REM_EN
    logic [RW-1:0]   r_rem_out;
`endif

    logic [c_vw-1:0] w_v;
    logic [C-1:0]    w_qk;
    logic [RW-1:0]   w_rk;
    logic [N-1:0]    w_shift_next;

    // Partial value for this step: running remainder followed by the next chunk.
    assign w_v = {r_rem, r_shift[N-1 -: C]};

    // One chunk stage: v / D and v mod D as a fixed compare-subtract chain
    // against the constant multiples D*2^k; it collapses to constant logic
    // and fits in one cycle because v < D*2^C keeps the quotient in C bits.
    always_comb begin
        logic [c_vw-1:0] rem;
        rem  = w_v;
        w_qk = '0;
        for (int k = C - 1; k >= 0; k--) begin
            if (rem >= (c_d << k)) begin
                w_qk[k] = 1'b1;
                rem     = rem - (c_d << k);
            end
        end
        w_rk = rem[RW-1:0];
    end

    // Quotient digit enters at the LSB end as the dividend leaves the MSB end.
    assign w_shift_next = (r_shift << C) | N'(w_qk);

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_quo       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef CDIV_REM_EN
            r_rem_out   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift    <= in_dividend;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_shift <= w_shift_next;
                    r_rem   <= w_rk;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        // Result registers are only written here, so they hold
                        // steady through any number of DONE stall cycles.
                        r_quo       <= w_shift_next;
`ifdef CDIV_REM_EN
                        r_rem_out   <= w_rk;
`endif
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign busy         = r_busy;
    assign out_quotient = r_quo;
`ifdef CDIV_REM_EN
    assign out_remainder = r_rem_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_const_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_const_div_seq
// Brief    : Scoreboard bench for const_div_seq. The driver pushes expected
//            results on each accepted dividend; a negedge monitor pops and
//            compares on every consumed result and checks result latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_const_div_seq;

    localparam int N     = 60;
    localparam int D     = 47;
    localparam int C     = 6;
    localparam int RW    = 6;
    localparam int STEPS = 10;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  in_dividend = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [N-1:0]  out_quotient;
`ifdef CDIV_REM_EN
    logic [RW-1:0] out_remainder;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit prev_ov  = 1'b0;

    logic [N-1:0]  exp_q[$];
    logic [RW-1:0] exp_r[$];
    int            acc_q[$];

    const_div_seq #(.N(N), .D(D), .C(C), .RW(RW), .STEPS(STEPS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
`ifdef CDIV_REM_EN
        .out_remainder(out_remainder),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // Offer one dividend and record what the monitor must see for it.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] eq,
                        input logic [RW-1:0] er, output int acc);
        int guard;
        guard = 0;
        acc   = 0;
        @(negedge clk);
        in_valid    = 1'b1;
        in_dividend = a;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            exp_q.push_back(eq);
            exp_r.push_back(er);
            acc_q.push_back(cyc);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_ov(output bit ok);
        int g;
        g  = 0;
        ok = 1'b0;
        while (!ok && g < 50) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
            g++;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    // Monitor: latency on each rising out_valid, values on each consumed result.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (acc_q.size() > 0) chk("latency", 64'(cyc - acc_q.pop_front()), 64'(STEPS));
                else fail_now("unexpected_out_valid");
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    chk("quotient", 64'(out_quotient), 64'(exp_q.pop_front()));
`ifdef CDIV_REM_EN
                    chk("remainder", 64'(out_remainder), 64'(exp_r.pop_front()));
`else
                    void'(exp_r.pop_front());
`endif
                end else begin
                    fail_now("unexpected_result");
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        int            a1;
        int            a2;
        bit            ok;
        logic [63:0]   rnd;
        logic [N-1:0]  x;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_quotient", 64'(out_quotient), 64'd0);
`ifdef CDIV_REM_EN
        chk("rst_remainder", 64'(out_remainder), 64'd0);
`endif
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Small values and the D boundary
        send(60'd0,  60'd0, 6'd0,  a1);
        send(60'd46, 60'd0, 6'd46, a1);
        send(60'd47, 60'd1, 6'd0,  a1);
        send(60'd93, 60'd1, 6'd46, a1);
        drain();

        // Full scale
        send({N{1'b1}}, 60'd24530244778869084, 6'd27, a1);
        drain();

        // Backpressure: 7 stall cycles in DONE with a competing in_valid
        out_ready = 1'b0;
        send(60'd123456789, 60'd2626740, 6'd9, a1);
        wait_ov(ok);
        if (!ok) fail_now("bp_out_valid");
        in_valid    = 1'b1;
        in_dividend = 60'd5;
        for (int i = 0; i < 7; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_quotient", 64'(out_quotient), 64'd2626740);
`ifdef CDIV_REM_EN
            chk("bp_remainder", 64'(out_remainder), 64'd9);
`endif
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (20) @(negedge clk);
        chk("ignored_in_valid", 64'(out_valid), 64'd0);
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of RUN
        send(60'd1000, 60'd21, 6'd13, a1);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_r.delete();
        acc_q.delete();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_quotient", 64'(out_quotient), 64'd0);
`ifdef CDIV_REM_EN
        chk("midrst_remainder", 64'(out_remainder), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        send(60'd94, 60'd2, 6'd0, a1);
        drain();

        // Back-to-back with out_ready held high
        send(60'd470, 60'd10, 6'd0, a1);
        send(60'd471, 60'd10, 6'd1, a2);
        chk("b2b_spacing", 64'(a2 - a1), 64'(STEPS + 2));
        drain();

        // Random dividends against the arithmetic reference
        for (int i = 0; i < 150; i++) begin
            rnd = {$urandom(), $urandom()};
            x   = rnd[N-1:0];
            send(x, x / N'(D), RW'(x % N'(D)), a1);
        end
        drain();

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
